mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 161 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: decodes RV32I width codes, drives a single-outstanding
// request/ready data bus, formats load data and reports misalignment, illegal codes and timeouts.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_mem,
    input  logic        mem_read_ctrl_mem,
    input  logic        mem_write_ctrl_mem,
    input  logic [2:0]  mem_funct3_mem,
    input  logic [31:0] alu_result_mem,
    input  logic [31:0] rs2_data_mem,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_be,
    input  logic        dbus_ready,
    input  logic [31:0] dbus_rdata,
    output logic [31:0] mem_data_out_mem,
    output logic        mem_stall,
    output logic        access_fault,
    output logic [1:0]  state_dbg
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t      r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic        r_timeout, r_is_load;
    logic [2:0]  r_f3;
    logic [1:0]  r_off;
    logic [31:0] r_addr, r_wdata, r_data_out;
    logic [3:0]  r_be;
    logic        r_we;

    logic        w_access, w_store, w_illegal, w_misal, w_bad, w_start, w_expire;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_load;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_access = valid_mem & (mem_read_ctrl_mem | mem_write_ctrl_mem);
    assign w_store  = mem_write_ctrl_mem;

    // Loads allow the unsigned byte/halfword codes; stores only the three signed ones.
    always_comb begin
        if (w_store) w_illegal = mem_funct3_mem[2] | (mem_funct3_mem[1:0] == 2'b11);
        else         w_illegal = (mem_funct3_mem == 3'b011) | (mem_funct3_mem[2:1] == 2'b11);
    end

    assign w_misal = ((mem_funct3_mem[1:0] == 2'b01) & alu_result_mem[0]) |
                     ((mem_funct3_mem[1:0] == 2'b10) & (alu_result_mem[1:0] != 2'b00));
    assign w_bad   = w_illegal | w_misal;
    assign w_start = w_access & ~w_bad;
    assign w_expire = (r_cnt == CNT_LAST);

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = rs2_data_mem;
        case (mem_funct3_mem[1:0])
            2'b00: begin
                w_be    = 4'b0001 << alu_result_mem[1:0];
                w_wdata = {4{rs2_data_mem[7:0]}};
            end
            2'b01: begin
                w_be    = alu_result_mem[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{rs2_data_mem[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte = dbus_rdata[7:0];
        case (r_off)
            2'd1:    w_byte = dbus_rdata[15:8];
            2'd2:    w_byte = dbus_rdata[23:16];
            2'd3:    w_byte = dbus_rdata[31:24];
            default: w_byte = dbus_rdata[7:0];
        endcase
        w_half = r_off[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
        case (r_f3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = dbus_rdata;
        endcase
    end

    always_comb begin
        w_next       = r_state;
        mem_stall    = 1'b0;
        access_fault = 1'b0;
        case (r_state)
            IDLE: begin
                mem_stall    = w_start;
                access_fault = w_access & w_bad;
                if (w_start) w_next = BUSY;
            end
            BUSY: begin
                mem_stall = 1'b1;
                if (dbus_ready || w_expire) w_next = DONE;
            end
            DONE: begin
                access_fault = r_timeout;
                w_next       = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_timeout  <= 1'b0;
            r_is_load  <= 1'b0;
            r_f3       <= 3'd0;
            r_off      <= 2'd0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_be       <= 4'd0;
            r_we       <= 1'b0;
            r_data_out <= 32'd0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_start) begin
                r_addr    <= {alu_result_mem[31:2], 2'b00};
                r_be      <= w_be;
                r_wdata   <= w_wdata;
                r_we      <= w_store;
                r_is_load <= ~w_store;
                r_f3      <= mem_funct3_mem;
                r_off     <= alu_result_mem[1:0];
                r_cnt     <= '0;
                r_timeout <= 1'b0;
            end else if (r_state == BUSY) begin
                if (dbus_ready) begin
                    if (r_is_load) r_data_out <= w_load;
                end else if (w_expire) begin
                    r_timeout <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign dbus_req         = (r_state == BUSY);
    assign dbus_we          = r_we;
    assign dbus_addr        = r_addr;
    assign dbus_wdata       = r_wdata;
    assign dbus_be          = r_be;
    assign mem_data_out_mem = r_data_out;
    assign state_dbg        = r_state;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table of load/store/fault vectors plus
// hand-written timeout and mid-access reset sequences.
module tb_mem_access_unit;
  logic        clk, rst_n;
  logic        valid_mem, mem_read_ctrl_mem, mem_write_ctrl_mem;
  logic [2:0]  mem_funct3_mem;
  logic [31:0] alu_result_mem, rs2_data_mem;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_ready;
  logic [31:0] dbus_rdata;
  logic [31:0] mem_data_out_mem;
  logic        mem_stall, access_fault;
  logic [1:0]  state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_mem(valid_mem), .mem_read_ctrl_mem(mem_read_ctrl_mem),
    .mem_write_ctrl_mem(mem_write_ctrl_mem), .mem_funct3_mem(mem_funct3_mem),
    .alu_result_mem(alu_result_mem), .rs2_data_mem(rs2_data_mem),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata), .dbus_be(dbus_be), .dbus_ready(dbus_ready),
    .dbus_rdata(dbus_rdata), .mem_data_out_mem(mem_data_out_mem),
    .mem_stall(mem_stall), .access_fault(access_fault), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, rs2, rdata;
    logic        fault;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_out;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    valid_mem = 1'b0; mem_read_ctrl_mem = 1'b0; mem_write_ctrl_mem = 1'b0;
    mem_funct3_mem = 3'd0; alu_result_mem = 32'd0; rs2_data_mem = 32'd0;
    dbus_ready = 1'b0; dbus_rdata = 32'd0;
  endtask

  task automatic drive_req(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] rs2);
    valid_mem = 1'b1; mem_read_ctrl_mem = rd; mem_write_ctrl_mem = wr;
    mem_funct3_mem = f3; alu_result_mem = addr; rs2_data_mem = rs2;
  endtask

  // One complete access with dbus_ready on the first BUSY cycle.
  task automatic run_vec(input vec_t v);
    logic [31:0] exp;
    @(negedge clk);
    drive_req(v.rd, v.wr, v.f3, v.addr, v.rs2);
    dbus_ready = 1'b0;
    #1;
    check("idle_fault", 32'(access_fault), 32'(v.fault));
    check("idle_stall", 32'(mem_stall), 32'(!v.fault));
    check("idle_req", 32'(dbus_req), 32'd0);
    if (v.fault) begin
      check("fault_data_out", mem_data_out_mem, v.e_out);
      @(posedge clk); #1;
      check("fault_stays_idle", 32'(state_dbg), 32'd0);
      drive_idle();
      return;
    end
    exp_q.push_back(v.e_out);
    @(posedge clk); #1;
    check("busy_req", 32'(dbus_req), 32'd1);
    check("busy_addr", dbus_addr, v.e_addr);
    check("busy_be", 32'(dbus_be), 32'(v.e_be));
    check("busy_we", 32'(dbus_we), 32'(v.wr));
    if (v.wr) check("busy_wdata", dbus_wdata, v.e_wdata);
    check("busy_stall", 32'(mem_stall), 32'd1);
    dbus_ready = 1'b1; dbus_rdata = v.rdata;
    @(posedge clk); #1;
    dbus_ready = 1'b0;
    exp = exp_q.pop_front();
    check("done_stall", 32'(mem_stall), 32'd0);
    check("done_fault", 32'(access_fault), 32'd0);
    check("done_req", 32'(dbus_req), 32'd0);
    check("done_data_out", mem_data_out_mem, exp);
    drive_idle();
    @(posedge clk); #1;
    check("back_idle", 32'(state_dbg), 32'd0);
  endtask

  vec_t vecs[14];
  vec_t v;
  int   req_cycles;

  initial begin
    //          rd wr f3      addr          rs2           rdata         flt e_addr        e_be     e_wdata       e_out
    vecs[0]  = '{1, 0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0, 32'h100, 4'b1111, 32'h0,        32'hDEADBEEF};
    vecs[1]  = '{1, 0, 3'b000, 32'h103, 32'h0,        32'h80FFFFFF, 0, 32'h100, 4'b1000, 32'h0,        32'hFFFFFF80};
    vecs[2]  = '{1, 0, 3'b100, 32'h103, 32'h0,        32'h80FFFFFF, 0, 32'h100, 4'b1000, 32'h0,        32'h00000080};
    vecs[3]  = '{1, 0, 3'b101, 32'h102, 32'h0,        32'h1234ABCD, 0, 32'h100, 4'b1100, 32'h0,        32'h00001234};
    vecs[4]  = '{1, 0, 3'b001, 32'h100, 32'h0,        32'h1234ABCD, 0, 32'h100, 4'b0011, 32'h0,        32'hFFFFABCD};
    vecs[5]  = '{1, 0, 3'b000, 32'h101, 32'h0,        32'h00007F00, 0, 32'h100, 4'b0010, 32'h0,        32'h0000007F};
    vecs[6]  = '{0, 1, 3'b001, 32'h006, 32'h0000CAFE, 32'hFFFFFFFF, 0, 32'h004, 4'b1100, 32'hCAFECAFE, 32'h0000007F};
    vecs[7]  = '{0, 1, 3'b000, 32'h011, 32'h123456AB, 32'hFFFFFFFF, 0, 32'h010, 4'b0010, 32'hABABABAB, 32'h0000007F};
    vecs[8]  = '{0, 1, 3'b010, 32'h020, 32'h89ABCDEF, 32'hFFFFFFFF, 0, 32'h020, 4'b1111, 32'h89ABCDEF, 32'h0000007F};
    vecs[9]  = '{1, 1, 3'b010, 32'h024, 32'h55AA33CC, 32'hFFFFFFFF, 0, 32'h024, 4'b1111, 32'h55AA33CC, 32'h0000007F};
    vecs[10] = '{1, 0, 3'b010, 32'h102, 32'h0,        32'h0,        1, 32'h0,   4'b0000, 32'h0,        32'h0000007F};
    vecs[11] = '{1, 0, 3'b011, 32'h100, 32'h0,        32'h0,        1, 32'h0,   4'b0000, 32'h0,        32'h0000007F};
    vecs[12] = '{0, 1, 3'b100, 32'h100, 32'h0,        32'h0,        1, 32'h0,   4'b0000, 32'h0,        32'h0000007F};
    vecs[13] = '{0, 1, 3'b001, 32'h005, 32'h0,        32'h0,        1, 32'h0,   4'b0000, 32'h0,        32'h0000007F};

    drive_idle();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_req", 32'(dbus_req), 32'd0);
    check("rst_addr", dbus_addr, 32'd0);
    check("rst_wdata", dbus_wdata, 32'd0);
    check("rst_be", 32'(dbus_be), 32'd0);
    check("rst_data_out", mem_data_out_mem, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // Timeout: ready never arrives, so the request is dropped after 4 BUSY cycles.
    @(negedge clk);
    drive_req(1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
    req_cycles = 0;
    @(posedge clk); #1;
    for (int k = 0; k < 20 && dbus_req; k++) begin
      req_cycles++;
      check("to_busy_stall", 32'(mem_stall), 32'd1);
      check("to_busy_fault", 32'(access_fault), 32'd0);
      @(posedge clk); #1;
    end
    check("to_req_cycles", 32'(req_cycles), 32'd4);
    check("to_state_done", 32'(state_dbg), 32'd2);
    check("to_fault_pulse", 32'(access_fault), 32'd1);
    check("to_stall_released", 32'(mem_stall), 32'd0);
    check("to_data_kept", mem_data_out_mem, 32'h0000007F);
    drive_idle();
    @(posedge clk); #1;
    check("to_fault_cleared", 32'(access_fault), 32'd0);
    check("to_back_idle", 32'(state_dbg), 32'd0);

    // Reset while BUSY abandons the access immediately.
    @(negedge clk);
    drive_req(1'b1, 1'b0, 3'b010, 32'h80, 32'h0);
    @(posedge clk); #1;
    check("rb_req_before", 32'(dbus_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rb_req_dropped", 32'(dbus_req), 32'd0);
    check("rb_state", 32'(state_dbg), 32'd0);
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rb_after_state", 32'(state_dbg), 32'd0);
    check("rb_after_req", 32'(dbus_req), 32'd0);
    check("rb_after_we", 32'(dbus_we), 32'd0);
    check("rb_after_addr", dbus_addr, 32'd0);
    check("rb_after_be", 32'(dbus_be), 32'd0);
    check("rb_after_data", mem_data_out_mem, 32'd0);
    check("rb_after_stall", 32'(mem_stall), 32'd0);
    check("rb_after_fault", 32'(access_fault), 32'd0);

    // Recovery: a normal load completes after the abandoned one.
    v = vecs[0];
    run_vec(v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
